win_scan_sequencer: RTL and testbench
=====================================

Name: win_scan_sequencer

Overview:
- Controller that sequences the four-in-a-row direction checker after every piece drop.
- Walks direction codes 1..13 in ascending order. Skips any direction whose four cells would fall off the board.
- Starts the checker once per legal direction and waits for its result.
- Forwards the checker's winning-piece coordinate stream to the board as mark writes, then reports the game result to the top-level game FSM.

Parameters:
ROWS, 6, board rows (row 0 = bottom); legal rows 0..ROWS-1
COLS, 7, board columns; legal columns 0..COLS-1
TIMEOUT, 15, max cycles to wait for chk_finished per direction before aborting

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
drop_valid  in  1  piece just placed; one-cycle pulse
drop_row  in  3  row of placed piece
drop_col  in  3  column of placed piece
busy  out  1  scan in progress; drop_valid ignored while high
done  out  1  one-cycle pulse at end of scan
win  out  1  at least one line found this scan; held until next accepted drop
winner  out  2  player code of the first winning line; 0 = none
lines_found  out  3  winning lines found this scan (saturates at 7)
timeout_err  out  1  checker failed to finish; held until next accepted drop
chk_start  out  1  start pulse to checker
chk_row  out  3  row presented to checker (= latched drop_row)
chk_col  out  3  column presented to checker (= latched drop_col)
chk_direction  out  4  direction code presented to checker
chk_finished  in  1  checker result valid
chk_winner  in  2  checker winner; 0 = empty line
chk_w_winning  in  1  checker winning-coordinate strobe
chk_winning_row  in  3  winning coordinate row
chk_winning_col  in  3  winning coordinate column
mark_we  out  1  write-enable to board winning-mask memory
mark_row  out  3  mark row (= chk_winning_row, combinational)
mark_col  out  3  mark column (= chk_winning_col, combinational)

Behaviour:
- Reset (synchronous, any state): state=IDLE, dir=1, all outputs 0, wait counter 0.
  - A reset mid-scan abandons the scan with no done pulse.
- IDLE:
  - On drop_valid, latch row and col, clear win/winner/lines_found/timeout_err, set dir=1, go SELECT.
  - busy=1 in every state except IDLE.
- SELECT (1 cycle per direction):
  - Let r, c be the latched coordinates, k = 1..4 the index within a group.
  - Legality: DOWN(1) needs r>=3. ROW_k needs c>=4-k and c+k-1<=COLS-1.
  - DIAG_RIGHT_UP_k (5+k) needs the row condition in r/ROWS plus the ROW_k column condition.
  - DIAG_LEFT_DOWN_k (9+k) needs r>=4-k, r+k-1<=ROWS-1, c>=k-1 and c+4-k<=COLS-1.
  - Evaluate with 4-bit unsigned arithmetic; never rely on 3-bit wrap.
  - Illegal: dir+1. Legal: go START. If dir would pass 13, go DONE.
- START:
  - chk_start=1 for exactly one cycle, with chk_direction=dir held stable from START until the next SELECT.
  - Go WAIT; clear the wait counter.
- WAIT:
  - Counter increments each cycle.
  - On chk_finished with chk_winner!=0: record winner if it is the first line, lines_found+1, go MARK.
  - On chk_finished with chk_winner==0: dir+1, go SELECT.
  - Counter reaching TIMEOUT: set timeout_err, go DONE.
  - Expected latency: chk_finished on the 6th cycle after START, i.e. 8 cycles per non-winning legal direction.
- mark_we = chk_w_winning in MARK, and in WAIT only in the same cycle as chk_finished. This gives exactly 4 mark writes per line, the first being the dropped piece.
- MARK:
  - Stay while chk_w_winning=1; on its fall go NEXT.
  - Time-out at TIMEOUT like WAIT.
- NEXT:
  - Without the optional feature: go DONE (stop at first win).
  - With it: dir+1, go SELECT.
- DONE: done=1 for one cycle, win=(lines_found!=0), go IDLE.
- drop_valid in any non-IDLE state is ignored (no queueing).
- Never issues chk_start while the checker is mid-operation; the next START is at least 2 cycles after chk_finished.

Optional Feature:
- Macro WIN_SCAN_ALL_DIRS_EN.
- Defined: after a winning line the scan continues through dir 13, so every winning line is marked and lines_found counts all of them.
- Undefined: the scan terminates at the first winning line; lines_found is 0 or 1.

Test Plan:
1. Empty board, drop at (0,0) -> chk_start pulses exactly twice, dir 5 then 9; no mark_we; done pulse; win=0, winner=0.
2. Player 1 pieces at row 0, cols 0-2; drop at (0,3) with dir 2 winning -> 4 mark_we cycles with coords (0,3),(0,0),(0,1),(0,2); winner=1; lines_found=1; done.
3. Drop at (3,3) completing both a vertical and a horizontal line, feature on -> 8 mark_we cycles, lines_found=2, winner = player of the first line (dir 1); feature off -> 4 mark_we cycles, lines_found=1.
4. Stub checker that never asserts chk_finished -> timeout_err=1 after TIMEOUT cycles in WAIT; done pulses; busy falls.
5. drop_valid pulsed again mid-scan -> ignored; latched coordinates and dir sequence unchanged.
6. rst asserted during MARK -> next cycle state IDLE, busy=0, mark_we=0, win=0, no done pulse.

Source files
------------

// File: rtl/win_scan_sequencer.sv
// win_scan_sequencer
// Sequences the four-in-a-row direction checker after each piece drop. It walks
// direction codes 1..13, skips directions that would leave the board, starts
// the checker once per legal direction, forwards the winning coordinate stream
// as board mark writes and reports the scan result.
// Optional feature macro: WIN_SCAN_ALL_DIRS_EN (keep scanning after a win).
module win_scan_sequencer #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       drop_valid,
    input  logic [2:0] drop_row,
    input  logic [2:0] drop_col,
    output logic       busy,
    output logic       done,
    output logic       win,
    output logic [1:0] winner,
    output logic [2:0] lines_found,
    output logic       timeout_err,
    output logic       chk_start,
    output logic [2:0] chk_row,
    output logic [2:0] chk_col,
    output logic [3:0] chk_direction,
    input  logic       chk_finished,
    input  logic [1:0] chk_winner,
    input  logic       chk_w_winning,
    input  logic [2:0] chk_winning_row,
    input  logic [2:0] chk_winning_col,
    output logic       mark_we,
    output logic [2:0] mark_row,
    output logic [2:0] mark_col
);

    localparam logic [3:0]  ROWS4     = 4'(ROWS);
    localparam logic [3:0]  COLS4     = 4'(COLS);
    localparam int unsigned CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [3:0]  DIR_FIRST = 4'd1;
    localparam logic [3:0]  DIR_LAST  = 4'd13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_WAIT,
        S_MARK,
        S_NEXT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      dir_q, dir_d;
    logic [2:0]      row_q, row_d;
    logic [2:0]      col_q, col_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            win_q, win_d;
    logic [1:0]      winner_q, winner_d;
    logic [2:0]      lines_q, lines_d;
    logic            tmo_q, tmo_d;
    logic            dir_ok;

    // Decides whether all four cells of direction d through (r, c) are on the
    // board. Inequalities are rearranged to additions so nothing can underflow.
    function automatic logic dir_legal(input logic [3:0] d,
                                       input logic [3:0] r,
                                       input logic [3:0] c);
        logic [3:0] k;
        logic       rows_ok;
        logic       cols_fwd;
        logic       cols_rev;
        logic       legal;
        if (d >= 4'd10)     k = d - 4'd9;
        else if (d >= 4'd6) k = d - 4'd5;
        else if (d >= 4'd2) k = d - 4'd1;
        else                k = 4'd0;
        // r >= 4-k and r+k-1 <= ROWS-1
        rows_ok  = (r + k >= 4'd4) && (r + k <= ROWS4);
        // c >= 4-k and c+k-1 <= COLS-1
        cols_fwd = (c + k >= 4'd4) && (c + k <= COLS4);
        // c >= k-1 and c+4-k <= COLS-1
        cols_rev = (c + 4'd1 >= k) && (c + 4'd5 <= COLS4 + k);
        if (d == 4'd0 || d > DIR_LAST) legal = 1'b0;
        else if (d == 4'd1)            legal = (r >= 4'd3);
        else if (d <= 4'd5)            legal = cols_fwd;
        else if (d <= 4'd9)            legal = rows_ok && cols_fwd;
        else                           legal = rows_ok && cols_rev;
        return legal;
    endfunction

    assign dir_ok = dir_legal(dir_q, {1'b0, row_q}, {1'b0, col_q});

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            dir_q    <= DIR_FIRST;
            row_q    <= '0;
            col_q    <= '0;
            cnt_q    <= '0;
            win_q    <= 1'b0;
            winner_q <= '0;
            lines_q  <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            row_q    <= row_d;
            col_q    <= col_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            winner_q <= winner_d;
            lines_q  <= lines_d;
            tmo_q    <= tmo_d;
        end
    end

    // Next-state, register updates and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        winner_d  = winner_q;
        lines_d   = lines_q;
        tmo_d     = tmo_q;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        chk_start = (state_q == S_START);
        mark_we   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (drop_valid) begin
                    row_d    = drop_row;
                    col_d    = drop_col;
                    win_d    = 1'b0;
                    winner_d = '0;
                    lines_d  = '0;
                    tmo_d    = 1'b0;
                    dir_d    = DIR_FIRST;
                    state_d  = S_SELECT;
                end
            end
            S_SELECT: begin
                if (dir_q > DIR_LAST) begin
                    state_d = S_DONE;
                end else if (dir_ok) begin
                    state_d = S_START;
                end else if (dir_q == DIR_LAST) begin
                    state_d = S_DONE;
                end else begin
                    dir_d = dir_q + 4'd1;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d   = cnt_q + 1'b1;
                mark_we = chk_finished && chk_w_winning;
                if (chk_finished) begin
                    if (chk_winner != 2'd0) begin
                        if (lines_q == '0) winner_d = chk_winner;
                        if (lines_q != 3'd7) lines_d = lines_q + 3'd1;
                        cnt_d   = '0;
                        state_d = S_MARK;
                    end else begin
                        dir_d   = dir_q + 4'd1;
                        state_d = S_SELECT;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_MARK: begin
                cnt_d   = cnt_q + 1'b1;
                mark_we = chk_w_winning;
                if (!chk_w_winning) begin
                    state_d = S_NEXT;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_NEXT: begin
`ifdef WIN_SCAN_ALL_DIRS_EN
                dir_d   = dir_q + 4'd1;
                state_d = S_SELECT;
`else
                state_d = S_DONE;
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // win becomes valid together with the done pulse and then holds.
        if (state_d == S_DONE) win_d = (lines_q != '0);
    end

    assign win           = win_q;
    assign winner        = winner_q;
    assign lines_found   = lines_q;
    assign timeout_err   = tmo_q;
    assign chk_row       = row_q;
    assign chk_col       = col_q;
    assign chk_direction = dir_q;
    assign mark_row      = chk_winning_row;
    assign mark_col      = chk_winning_col;

endmodule

// File: tb/tb_win_scan_sequencer.sv
// Self-checking bench for win_scan_sequencer with a behavioural checker stub
// that answers six cycles after each start and can stream a winning line.
module tb_win_scan_sequencer;

    logic       clk;
    logic       rst;
    logic       drop_valid;
    logic [2:0] drop_row;
    logic [2:0] drop_col;
    logic       busy;
    logic       done;
    logic       win;
    logic [1:0] winner;
    logic [2:0] lines_found;
    logic       timeout_err;
    logic       chk_start;
    logic [2:0] chk_row;
    logic [2:0] chk_col;
    logic [3:0] chk_direction;
    logic       chk_finished;
    logic [1:0] chk_winner;
    logic       chk_w_winning;
    logic [2:0] chk_winning_row;
    logic [2:0] chk_winning_col;
    logic       mark_we;
    logic [2:0] mark_row;
    logic [2:0] mark_col;

    win_scan_sequencer #(
        .ROWS    (6),
        .COLS    (7),
        .TIMEOUT (15)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .drop_valid      (drop_valid),
        .drop_row        (drop_row),
        .drop_col        (drop_col),
        .busy            (busy),
        .done            (done),
        .win             (win),
        .winner          (winner),
        .lines_found     (lines_found),
        .timeout_err     (timeout_err),
        .chk_start       (chk_start),
        .chk_row         (chk_row),
        .chk_col         (chk_col),
        .chk_direction   (chk_direction),
        .chk_finished    (chk_finished),
        .chk_winner      (chk_winner),
        .chk_w_winning   (chk_w_winning),
        .chk_winning_row (chk_winning_row),
        .chk_winning_col (chk_winning_col),
        .mark_we         (mark_we),
        .mark_row        (mark_row),
        .mark_col        (mark_col)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Checker stub configuration
    logic [1:0] stub_winner [16];
    logic [2:0] stub_wr     [16][4];
    logic [2:0] stub_wc     [16][4];
    logic       stub_hang = 1'b0;

    // Monitor state
    int unsigned mon_starts, mon_busy, mon_marks, mon_done;
    int unsigned mon_order_bad, mon_coord_bad, mon_last_dir;
    logic [15:0] mon_mask;
    logic [2:0]  mon_mr [8];
    logic [2:0]  mon_mc [8];
    logic [2:0]  exp_r, exp_c;

    typedef struct {
        logic [2:0]  r;
        logic [2:0]  c;
        logic [15:0] mask;
        int unsigned starts;
        int unsigned busy_cyc;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic mon_clear();
        mon_starts    = 0;
        mon_busy      = 0;
        mon_marks     = 0;
        mon_done      = 0;
        mon_order_bad = 0;
        mon_coord_bad = 0;
        mon_last_dir  = 0;
        mon_mask      = '0;
    endtask

    task automatic stub_clear();
        for (int d = 0; d < 16; d++) begin
            stub_winner[d] = 2'd0;
            for (int k = 0; k < 4; k++) begin
                stub_wr[d][k] = 3'd0;
                stub_wc[d][k] = 3'd0;
            end
        end
    endtask

    function automatic logic [23:0] marks4();
        return {mon_mr[0], mon_mc[0], mon_mr[1], mon_mc[1],
                mon_mr[2], mon_mc[2], mon_mr[3], mon_mc[3]};
    endfunction

    task automatic do_drop(input logic [2:0] r, input logic [2:0] c);
        mon_clear();
        exp_r = r;
        exp_c = c;
        @(negedge clk);
        drop_valid = 1'b1;
        drop_row   = r;
        drop_col   = c;
        @(negedge clk);
        drop_valid = 1'b0;
    endtask

    // Waits (bounded) for the done pulse, then one more cycle so held
    // results are read after the scan has returned to idle.
    task automatic wait_done(input string nm);
        int unsigned n;
        n = 0;
        while (mon_done == 0 && n < 300) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk(nm, 32'(mon_done != 0), 32'd1);
        @(negedge clk);
        #3;
    endtask

    // Checker stub: answers on the 6th cycle after a start, streaming the four
    // winning coordinates (first one together with chk_finished) on a win.
    initial begin
        int d;
        chk_finished    = 1'b0;
        chk_winner      = 2'd0;
        chk_w_winning   = 1'b0;
        chk_winning_row = 3'd0;
        chk_winning_col = 3'd0;
        forever begin
            @(negedge clk);
            if (chk_start === 1'b1 && !stub_hang) begin
                d = int'(chk_direction);
                repeat (6) @(negedge clk);
                chk_finished = 1'b1;
                chk_winner   = stub_winner[d];
                if (stub_winner[d] != 2'd0) begin
                    for (int k = 0; k < 4; k++) begin
                        if (k != 0) begin
                            @(negedge clk);
                            chk_finished = 1'b0;
                            chk_winner   = 2'd0;
                        end
                        chk_w_winning   = 1'b1;
                        chk_winning_row = stub_wr[d][k];
                        chk_winning_col = stub_wc[d][k];
                    end
                end
                @(negedge clk);
                chk_finished  = 1'b0;
                chk_winner    = 2'd0;
                chk_w_winning = 1'b0;
            end
        end
    end

    // Monitor: samples DUT outputs mid-cycle, well away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (busy === 1'b1) mon_busy++;
            if (done === 1'b1) mon_done++;
            if (chk_start === 1'b1) begin
                mon_starts++;
                mon_mask[chk_direction] = 1'b1;
                if (32'(chk_direction) <= mon_last_dir) mon_order_bad++;
                mon_last_dir = 32'(chk_direction);
                if (chk_row !== exp_r || chk_col !== exp_c) mon_coord_bad++;
            end
            if (mark_we === 1'b1) begin
                if (mon_marks < 8) begin
                    mon_mr[mon_marks] = mark_row;
                    mon_mc[mon_marks] = mark_col;
                end
                mon_marks++;
            end
        end
    end

    initial begin
        int unsigned n;
        // Legal-direction vectors on an empty board: mask bit n = direction n.
        vecs[0] = '{r: 3'd0, c: 3'd0, mask: 16'h0220, starts: 2,  busy_cyc: 28};
        vecs[1] = '{r: 3'd0, c: 3'd6, mask: 16'h2004, starts: 2,  busy_cyc: 29};
        vecs[2] = '{r: 3'd5, c: 3'd0, mask: 16'h0422, starts: 3,  busy_cyc: 35};
        vecs[3] = '{r: 3'd3, c: 3'd3, mask: 16'h1DFE, starts: 11, busy_cyc: 91};
        vecs[4] = '{r: 3'd2, c: 3'd6, mask: 16'h2004, starts: 2,  busy_cyc: 29};
        vecs[5] = '{r: 3'd5, c: 3'd6, mask: 16'h0046, starts: 3,  busy_cyc: 35};
        vecs[6] = '{r: 3'd1, c: 3'd3, mask: 16'h333C, starts: 8,  busy_cyc: 71};

        rst        = 1'b1;
        drop_valid = 1'b0;
        drop_row   = 3'd0;
        drop_col   = 3'd0;
        exp_r      = 3'd0;
        exp_c      = 3'd0;
        stub_clear();
        mon_clear();

        // Reset state
        repeat (3) @(negedge clk);
        #3;
        chk("reset_outputs",
            32'({busy, done, win, winner, lines_found, timeout_err, chk_start,
                 chk_row, chk_col, mark_we}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("post_reset_idle", 32'({busy, done, win, timeout_err}), 32'd0);

        // Direction walk on an empty board
        for (int i = 0; i < 7; i++) begin
            do_drop(vecs[i].r, vecs[i].c);
            wait_done($sformatf("v%0d_done", i));
            chk($sformatf("v%0d_mask", i),      32'(mon_mask),      32'(vecs[i].mask));
            chk($sformatf("v%0d_starts", i),    mon_starts,         vecs[i].starts);
            chk($sformatf("v%0d_busy_cyc", i),  mon_busy,           vecs[i].busy_cyc);
            chk($sformatf("v%0d_order", i),     mon_order_bad,      32'd0);
            chk($sformatf("v%0d_coords", i),    mon_coord_bad,      32'd0);
            chk($sformatf("v%0d_marks", i),     mon_marks,          32'd0);
            chk($sformatf("v%0d_result", i),
                32'({busy, win, winner, lines_found, timeout_err}), 32'd0);
            chk($sformatf("v%0d_done_cnt", i),  mon_done,           32'd1);
        end

        // Horizontal win: row 0 cols 0-2 plus drop at (0,3), direction 2
        stub_clear();
        stub_winner[2] = 2'd1;
        stub_wr[2][0] = 3'd0; stub_wc[2][0] = 3'd3;
        stub_wr[2][1] = 3'd0; stub_wc[2][1] = 3'd0;
        stub_wr[2][2] = 3'd0; stub_wc[2][2] = 3'd1;
        stub_wr[2][3] = 3'd0; stub_wc[2][3] = 3'd2;
        do_drop(3'd0, 3'd3);
        wait_done("h_done");
        chk("h_marks", mon_marks, 32'd4);
        chk("h_mark_coords", 32'(marks4()),
            32'({3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd2}));
        chk("h_win", 32'({win, winner, lines_found}), 32'({1'b1, 2'd1, 3'd1}));
        chk("h_done_cnt", mon_done, 32'd1);
`ifdef WIN_SCAN_ALL_DIRS_EN
        chk("h_starts", mon_starts, 32'd6);
`else
        chk("h_starts", mon_starts, 32'd1);
        chk("h_busy_cyc", mon_busy, 32'd15);
`endif

        // Vertical (dir 1) and horizontal (dir 2) lines through (3,3)
        stub_clear();
        stub_winner[1] = 2'd2;
        stub_wr[1][0] = 3'd3; stub_wc[1][0] = 3'd3;
        stub_wr[1][1] = 3'd2; stub_wc[1][1] = 3'd3;
        stub_wr[1][2] = 3'd1; stub_wc[1][2] = 3'd3;
        stub_wr[1][3] = 3'd0; stub_wc[1][3] = 3'd3;
        stub_winner[2] = 2'd2;
        stub_wr[2][0] = 3'd3; stub_wc[2][0] = 3'd3;
        stub_wr[2][1] = 3'd3; stub_wc[2][1] = 3'd0;
        stub_wr[2][2] = 3'd3; stub_wc[2][2] = 3'd1;
        stub_wr[2][3] = 3'd3; stub_wc[2][3] = 3'd2;
        do_drop(3'd3, 3'd3);
        wait_done("two_done");
        chk("two_mark_coords", 32'(marks4()),
            32'({3'd3, 3'd3, 3'd2, 3'd3, 3'd1, 3'd3, 3'd0, 3'd3}));
        chk("two_winner", 32'({win, winner}), 32'({1'b1, 2'd2}));
`ifdef WIN_SCAN_ALL_DIRS_EN
        chk("two_marks", mon_marks, 32'd8);
        chk("two_lines", 32'(lines_found), 32'd2);
        chk("two_starts", mon_starts, 32'd11);
`else
        chk("two_marks", mon_marks, 32'd4);
        chk("two_lines", 32'(lines_found), 32'd1);
        chk("two_starts", mon_starts, 32'd1);
`endif

        // Checker never finishes: time-out after TIMEOUT cycles in WAIT
        stub_clear();
        stub_hang = 1'b1;
        do_drop(3'd0, 3'd0);
        wait_done("tmo_done");
        chk("tmo_flag", 32'(timeout_err), 32'd1);
        chk("tmo_result", 32'({busy, win, winner, lines_found}), 32'd0);
        chk("tmo_starts", mon_starts, 32'd1);
        chk("tmo_busy_cyc", mon_busy, 32'd22);
        stub_hang = 1'b0;

        // Second drop mid-scan must be ignored
        do_drop(3'd3, 3'd3);
        repeat (20) @(negedge clk);
        drop_valid = 1'b1;
        drop_row   = 3'd0;
        drop_col   = 3'd0;
        @(negedge clk);
        drop_valid = 1'b0;
        wait_done("ign_done");
        chk("ign_mask", 32'(mon_mask), 32'h1DFE);
        chk("ign_coords", mon_coord_bad, 32'd0);
        chk("ign_busy_cyc", mon_busy, 32'd91);
        chk("ign_tmo_cleared", 32'(timeout_err), 32'd0);
        repeat (5) @(negedge clk);
        #3;
        chk("ign_no_rescan", 32'({mon_done[3:0], busy}), 32'({4'd1, 1'b0}));

        // Reset while marking a winning line
        stub_clear();
        stub_winner[2] = 2'd1;
        stub_wr[2][0] = 3'd0; stub_wc[2][0] = 3'd3;
        stub_wr[2][1] = 3'd0; stub_wc[2][1] = 3'd0;
        stub_wr[2][2] = 3'd0; stub_wc[2][2] = 3'd1;
        stub_wr[2][3] = 3'd0; stub_wc[2][3] = 3'd2;
        do_drop(3'd0, 3'd3);
        n = 0;
        while (mon_marks < 2 && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("rst_reach_mark", 32'(mon_marks >= 2), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("rst_idle", 32'({busy, mark_we, win, done}), 32'd0);
        repeat (20) @(negedge clk);
        #3;
        chk("rst_no_done", mon_done, 32'd0);
        chk("rst_marks", mon_marks, 32'd3);
        chk("rst_result", 32'({busy, win, winner, lines_found}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
